// File: rtl/gouram_trace_ctrl.sv
// Trace capture controller: arms on a start address, buffers tracer records in a
// first-word-fall-through FIFO until a stop address or tracer lock, then drains to the sink.
module gouram_trace_ctrl #(
    parameter int unsigned REC_WIDTH  = 128,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] cfg_start_addr,
    input  logic [ADDR_WIDTH-1:0] cfg_stop_addr,
    input  logic                  cfg_arm,
    input  logic                  cfg_abort,
    input  logic                  trace_valid_i,
    input  logic [REC_WIDTH-1:0]  trace_rec_i,
    input  logic [ADDR_WIDTH-1:0] trace_addr_i,
    input  logic                  lock_i,
    output logic                  out_valid,
    output logic [REC_WIDTH-1:0]  out_data,
    input  logic                  out_ready,
    output logic                  capture_en_o,
    output logic [2:0]            state_o,
    output logic [15:0]           captured_o,
    output logic [15:0]           dropped_o,
    output logic                  lock_seen_o,
    output logic                  done_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned STAT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_CAPTURE = 3'd2,
        S_DRAIN   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [REC_WIDTH-1:0]  r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [STAT_W-1:0]     r_captured;
    logic [STAT_W-1:0]     r_dropped;
    logic                  r_lock_seen;

    logic w_start_hit;
    logic w_stop_hit;
    logic w_push_req;
    logic w_arm;
    logic w_lock_set;
    logic w_full;
    logic w_pop;
    logic w_accept;
    logic w_drop;

    assign w_start_hit = trace_valid_i && (trace_addr_i == cfg_start_addr);
    assign w_stop_hit  = trace_valid_i && (trace_addr_i == cfg_stop_addr);
    assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign out_valid   = (r_count != '0);
    assign w_pop       = out_valid && out_ready;
    // A full FIFO still takes a record when the head leaves in the same cycle.
    assign w_accept    = w_push_req && (!w_full || w_pop);
    assign w_drop      = w_push_req && w_full && !w_pop;

    // Next-state and push/arm decode; abort overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_push_req  = 1'b0;
        w_arm       = 1'b0;
        w_lock_set  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cfg_arm) begin
                    w_state_nxt = S_ARMED;
                    w_arm       = 1'b1;
                end
            end
            S_ARMED: begin
                if (w_start_hit) begin
                    w_push_req  = 1'b1;
                    w_state_nxt = w_stop_hit ? S_DRAIN : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                w_push_req = trace_valid_i;
                w_lock_set = lock_i;
                if (w_stop_hit || lock_i) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((r_count == '0) || ((r_count == CNT_W'(1)) && w_pop)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (cfg_arm) begin
                    w_state_nxt = S_ARMED;
                    w_arm       = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (cfg_abort) begin
            w_state_nxt = S_IDLE;
            w_push_req  = 1'b0;
            w_arm       = 1'b0;
            w_lock_set  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_captured  <= '0;
            r_dropped   <= '0;
            r_lock_seen <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (cfg_abort) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_accept) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_pop);
            end
            // Statistics saturate rather than wrap.
            if (w_arm) begin
                r_captured <= '0;
            end else if (w_accept && (r_captured != '1)) begin
                r_captured <= r_captured + STAT_W'(1);
            end
            if (w_arm) begin
                r_dropped <= '0;
            end else if (w_drop && (r_dropped != '1)) begin
                r_dropped <= r_dropped + STAT_W'(1);
            end
            if (w_arm) begin
                r_lock_seen <= 1'b0;
            end else if (w_lock_set) begin
                r_lock_seen <= 1'b1;
            end
        end
    end

    // Record storage needs no reset; out_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= trace_rec_i;
        end
    end

    assign out_data     = out_valid ? r_mem[r_rd_ptr] : '0;
    assign state_o      = 3'(r_state);
    assign capture_en_o = (r_state == S_ARMED) || (r_state == S_CAPTURE);
    assign done_o       = (r_state == S_DONE);
    assign captured_o   = r_captured;
    assign dropped_o    = r_dropped;
    assign lock_seen_o  = r_lock_seen;

endmodule

// File: tb/tb_gouram_trace_ctrl.sv
// Directed, table-driven bench for gouram_trace_ctrl; records carry their address
// replicated across the payload so the head can be checked against the address.
module tb_gouram_trace_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [15:0]  cfg_start_addr;
    logic [15:0]  cfg_stop_addr;
    logic         cfg_arm;
    logic         cfg_abort;
    logic         trace_valid_i;
    logic [127:0] trace_rec_i;
    logic [15:0]  trace_addr_i;
    logic         lock_i;
    logic         out_valid;
    logic [127:0] out_data;
    logic         out_ready;
    logic         capture_en_o;
    logic [2:0]   state_o;
    logic [15:0]  captured_o;
    logic [15:0]  dropped_o;
    logic         lock_seen_o;
    logic         done_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gouram_trace_ctrl #(
        .REC_WIDTH (128),
        .ADDR_WIDTH(16),
        .FIFO_DEPTH(8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_start_addr(cfg_start_addr),
        .cfg_stop_addr (cfg_stop_addr),
        .cfg_arm       (cfg_arm),
        .cfg_abort     (cfg_abort),
        .trace_valid_i (trace_valid_i),
        .trace_rec_i   (trace_rec_i),
        .trace_addr_i  (trace_addr_i),
        .lock_i        (lock_i),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_ready     (out_ready),
        .capture_en_o  (capture_en_o),
        .state_o       (state_o),
        .captured_o    (captured_o),
        .dropped_o     (dropped_o),
        .lock_seen_o   (lock_seen_o),
        .done_o        (done_o)
    );

    typedef struct {
        logic        rst;
        logic        arm;
        logic        abort;
        logic        tv;
        logic [15:0] addr;
        logic        lock;
        logic        rdy;
        logic [2:0]  st;
        logic        v;
        logic [15:0] d;
        logic [15:0] cap;
        logic [15:0] drp;
        logic        lk;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic arm, input logic abort,
                                input logic tv, input logic [15:0] addr, input logic lock,
                                input logic rdy, input logic [2:0] st, input logic v,
                                input logic [15:0] d, input logic [15:0] cap,
                                input logic [15:0] drp, input logic lk);
        vec_t x;
        x.rst = rst; x.arm = arm; x.abort = abort; x.tv = tv; x.addr = addr;
        x.lock = lock; x.rdy = rdy; x.st = st; x.v = v; x.d = d;
        x.cap = cap; x.drp = drp; x.lk = lk;
        return x;
    endfunction

    task automatic check(input string nm, input int idx, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step%0d actual=%0h expected=%0h", nm, idx, act, exp);
        end
    endtask

    task automatic check_outputs(input vec_t x, input int idx);
        logic [127:0] exp_data;
        exp_data = x.v ? {8{x.d}} : 128'h0;
        check("state",      idx, 128'(state_o),      128'(x.st));
        check("out_valid",  idx, 128'(out_valid),    128'(x.v));
        check("out_data",   idx, out_data,           exp_data);
        check("captured",   idx, 128'(captured_o),   128'(x.cap));
        check("dropped",    idx, 128'(dropped_o),    128'(x.drp));
        check("lock_seen",  idx, 128'(lock_seen_o),  128'(x.lk));
        check("capture_en", idx, 128'(capture_en_o), 128'((x.st == 3'd1) || (x.st == 3'd2)));
        check("done",       idx, 128'(done_o),       128'(x.st == 3'd4));
    endtask

    // Drive one cycle of inputs at the falling edge, check just after the next rising edge.
    task automatic apply(input vec_t x, input int idx);
        @(negedge clk);
        rst_n         = !x.rst;
        cfg_arm       = x.arm;
        cfg_abort     = x.abort;
        trace_valid_i = x.tv;
        trace_addr_i  = x.addr;
        trace_rec_i   = {8{x.addr}};
        lock_i        = x.lock;
        out_ready     = x.rdy;
        @(posedge clk);
        #1;
        check_outputs(x, idx);
    endtask

    initial begin
        rst_n = 1'b0; cfg_arm = 1'b0; cfg_abort = 1'b0; trace_valid_i = 1'b0;
        trace_addr_i = '0; trace_rec_i = '0; lock_i = 1'b0; out_ready = 1'b0;
        cfg_start_addr = 16'h0100;
        cfg_stop_addr  = 16'h0110;

        // Normal session: one non-matching record, then start..stop with sink ready.
        vecs.push_back(mk(0,1,0,0,16'h0000,0,0, 3'd1,0,16'h0000,0,0,0));
        vecs.push_back(mk(0,0,0,1,16'h00F0,0,1, 3'd1,0,16'h0000,0,0,0));
        vecs.push_back(mk(0,0,0,1,16'h0100,0,1, 3'd2,1,16'h0100,1,0,0));
        vecs.push_back(mk(0,0,0,1,16'h0104,0,1, 3'd2,1,16'h0104,2,0,0));
        vecs.push_back(mk(0,0,0,1,16'h0108,0,1, 3'd2,1,16'h0108,3,0,0));
        vecs.push_back(mk(0,0,0,1,16'h0110,0,1, 3'd3,1,16'h0110,4,0,0));
        vecs.push_back(mk(0,0,0,0,16'h0000,0,1, 3'd4,0,16'h0000,4,0,0));
        vecs.push_back(mk(0,0,0,0,16'h0000,0,1, 3'd4,0,16'h0000,4,0,0));
        // Overflow: twelve records with sink stalled, head must hold steady.
        vecs.push_back(mk(0,1,0,0,16'h0000,0,0, 3'd1,0,16'h0000,0,0,0));
        vecs.push_back(mk(0,0,0,1,16'h0100,0,0, 3'd2,1,16'h0100,1,0,0));
        for (int k = 0; k < 11; k++) begin
            vecs.push_back(mk(0,0,0,1,16'(16'h0120 + 4*k),0,0, 3'd2,1,16'h0100,
                              16'(k < 7 ? k + 2 : 8), 16'(k < 7 ? 0 : k - 6), 0));
        end
        // Full FIFO: push with pop accepted, then push without pop dropped.
        vecs.push_back(mk(0,0,0,1,16'h014C,0,1, 3'd2,1,16'h0120,9,4,0));
        vecs.push_back(mk(0,0,0,1,16'h0150,0,0, 3'd2,1,16'h0120,9,5,0));
        vecs.push_back(mk(0,0,0,0,16'h0000,1,0, 3'd3,1,16'h0120,9,5,1));
        vecs.push_back(mk(0,0,0,0,16'h0000,0,1, 3'd3,1,16'h0124,9,5,1));
        vecs.push_back(mk(0,0,0,0,16'h0000,0,1, 3'd3,1,16'h0128,9,5,1));
        vecs.push_back(mk(0,0,0,0,16'h0000,0,1, 3'd3,1,16'h012C,9,5,1));
        vecs.push_back(mk(0,0,0,0,16'h0000,0,1, 3'd3,1,16'h0130,9,5,1));
        vecs.push_back(mk(0,0,0,0,16'h0000,0,1, 3'd3,1,16'h0134,9,5,1));
        vecs.push_back(mk(0,0,0,0,16'h0000,0,1, 3'd3,1,16'h0138,9,5,1));
        vecs.push_back(mk(0,0,0,0,16'h0000,0,1, 3'd3,1,16'h014C,9,5,1));
        vecs.push_back(mk(0,0,0,0,16'h0000,0,1, 3'd4,0,16'h0000,9,5,1));
        // Lock with a record in the same cycle.
        vecs.push_back(mk(0,1,0,0,16'h0000,0,0, 3'd1,0,16'h0000,0,0,0));
        vecs.push_back(mk(0,0,0,1,16'h0100,0,0, 3'd2,1,16'h0100,1,0,0));
        vecs.push_back(mk(0,0,0,1,16'h0160,1,0, 3'd3,1,16'h0100,2,0,1));
        vecs.push_back(mk(0,0,0,0,16'h0000,0,1, 3'd3,1,16'h0160,2,0,1));
        vecs.push_back(mk(0,0,0,0,16'h0000,0,1, 3'd4,0,16'h0000,2,0,1));
        // Arm ignored in CAPTURE; abort with arm and push beats both.
        vecs.push_back(mk(0,1,0,0,16'h0000,0,0, 3'd1,0,16'h0000,0,0,0));
        vecs.push_back(mk(0,0,0,1,16'h0100,0,0, 3'd2,1,16'h0100,1,0,0));
        vecs.push_back(mk(0,1,0,1,16'h0170,0,0, 3'd2,1,16'h0100,2,0,0));
        vecs.push_back(mk(0,0,0,1,16'h0174,0,0, 3'd2,1,16'h0100,3,0,0));
        vecs.push_back(mk(0,0,0,1,16'h0178,0,0, 3'd2,1,16'h0100,4,0,0));
        vecs.push_back(mk(0,0,0,1,16'h017C,0,0, 3'd2,1,16'h0100,5,0,0));
        vecs.push_back(mk(0,1,1,1,16'h0180,0,0, 3'd0,0,16'h0000,5,0,0));
        vecs.push_back(mk(0,0,0,0,16'h0000,0,1, 3'd0,0,16'h0000,5,0,0));
        vecs.push_back(mk(0,1,0,0,16'h0000,0,0, 3'd1,0,16'h0000,0,0,0));

        // Reset values while rst_n is held low.
        repeat (3) @(posedge clk);
        #1;
        check_outputs(mk(1,0,0,0,16'h0000,0,0, 3'd0,0,16'h0000,0,0,0), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i + 1);
        end

        // Start and stop on the same address: ARMED goes straight to DRAIN.
        cfg_start_addr = 16'h0200;
        cfg_stop_addr  = 16'h0200;
        apply(mk(0,0,0,1,16'h0200,0,0, 3'd3,1,16'h0200,1,0,0), 100);
        apply(mk(0,0,0,0,16'h0000,0,1, 3'd4,0,16'h0000,1,0,0), 101);
        cfg_start_addr = 16'h0100;
        cfg_stop_addr  = 16'h0110;

        // Reset mid-CAPTURE discards buffered records and statistics.
        apply(mk(0,1,0,0,16'h0000,0,0, 3'd1,0,16'h0000,0,0,0), 200);
        apply(mk(0,0,0,1,16'h0100,0,0, 3'd2,1,16'h0100,1,0,0), 201);
        apply(mk(0,0,0,1,16'h0104,0,0, 3'd2,1,16'h0100,2,0,0), 202);
        apply(mk(1,0,0,1,16'h0108,0,0, 3'd0,0,16'h0000,0,0,0), 203);
        apply(mk(0,0,0,0,16'h0000,0,1, 3'd0,0,16'h0000,0,0,0), 204);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
